// File: rtl/ex_mdu_if.sv
// EX-stage multiply/divide unit port bundle: operation request in, HI/LO state and move-from result out.
// The pipeline side is the master; the MDU is the slave.
interface ex_mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        except;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_rd;

    modport master (
        output start, op, A, B, except,
        input  busy, HI, LO, mdu_rd
    );

    modport slave (
        input  start, op, A, B, except,
        output busy, HI, LO, mdu_rd
    );
endinterface

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO; also serves mthi/mtlo/mfhi/mflo.
// Latency: mult MULT_CYCLES, div DIV_CYCLES, moves write at accept; backpressure: busy stalls MD ops, any issued while busy are dropped.
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    ex_mdu_if.slave mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_e;

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    op_e           op_q;
    logic          busy;
    logic          accept;

    logic [63:0]   prod;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   num;
    logic [31:0]   den;
    logic [31:0]   den_safe;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   quo;
    logic [31:0]   rem;

    assign busy   = (cnt != '0);
    assign accept = mdu.start && !mdu.except && !busy &&
                    (mdu.op >= OP_MULT) && (mdu.op <= OP_MTLO);

    // Signed divide works on magnitudes so INT_MIN / -1 wraps instead of overflowing.
    always_comb begin
        a_neg    = (op_q == OP_DIV) && a_q[31];
        b_neg    = (op_q == OP_DIV) && b_q[31];
        num      = a_neg ? -a_q : a_q;
        den      = b_neg ? -b_q : b_q;
        den_safe = (den == 32'd0) ? 32'd1 : den;
        q_mag    = num / den_safe;
        r_mag    = num % den_safe;
        quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;
        if (op_q == OP_MULT) begin
            prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        end else begin
            prod = {32'd0, a_q} * {32'd0, b_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= OP_NONE;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
                end else if (b_q != 32'd0) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end
        end else if (accept) begin
            case (mdu.op)
                OP_MULT, OP_MULTU: begin
                    a_q  <= mdu.A;
                    b_q  <= mdu.B;
                    op_q <= op_e'(mdu.op);
                    cnt  <= CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    a_q  <= mdu.A;
                    b_q  <= mdu.B;
                    op_q <= op_e'(mdu.op);
                    cnt  <= CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_q <= mdu.A;
                OP_MTLO: lo_q <= mdu.A;
                default: ;
            endcase
        end
    end

    assign mdu.busy   = busy;
    assign mdu.HI     = hi_q;
    assign mdu.LO     = lo_q;
    assign mdu.mdu_rd = (mdu.op == OP_MFHI) ? hi_q :
                        (mdu.op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_ex_mdu.sv
// Directed plus randomized bench for ex_mdu against a plain-arithmetic HI/LO model.
module tb_ex_mdu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mdu_if mif();
    ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .mdu(mif));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of a completed MD instruction on HI/LO.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
            4'd4: if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the first negedge where busy reads 0.
    // kind 1: except pulse on busy cycle 3; kind 2: stray mult start on busy cycle 3.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int kind, input string tag);
        int n;
        int exp_n;
        exp_n = (op <= 4'd2) ? 5 : 10;
        mif.start = 1'b1; mif.op = op; mif.A = a; mif.B = b; mif.except = 1'b0;
        @(negedge clk);
        mif.start = 1'b0; mif.op = 4'd0; mif.A = $urandom; mif.B = $urandom;
        n = 0;
        while (mif.busy === 1'b1 && n < 40) begin
            n++;
            mif.except = (kind == 1 && n == 3);
            mif.start  = (kind == 2 && n == 3);
            mif.op     = (kind == 2 && n == 3) ? 4'd1 : 4'd0;
            @(negedge clk);
        end
        mif.except = 1'b0; mif.start = 1'b0; mif.op = 4'd0;
        model(op, a, b);
        check({tag, "_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_hi"}, mif.HI, m_hi);
        check({tag, "_lo"}, mif.LO, m_lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        mif.start = 1'b0; mif.op = 4'd0; mif.A = 32'd0; mif.B = 32'd0; mif.except = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_busy", {31'd0, mif.busy}, 32'd0);
        check("rst_hi", mif.HI, 32'd0);
        check("rst_lo", mif.LO, 32'd0);

        run_md(4'd1, 32'hFFFFFFFF, 32'd2, 0, "mult");
        check("mult_hi_const", mif.HI, 32'hFFFFFFFF);
        check("mult_lo_const", mif.LO, 32'hFFFFFFFE);
        run_md(4'd2, 32'hFFFFFFFF, 32'd2, 0, "multu");
        check("multu_hi_const", mif.HI, 32'h00000001);
        check("multu_lo_const", mif.LO, 32'hFFFFFFFE);
        run_md(4'd3, 32'hFFFFFFF9, 32'd2, 0, "div");
        check("div_hi_const", mif.HI, 32'hFFFFFFFF);
        check("div_lo_const", mif.LO, 32'hFFFFFFFD);
        run_md(4'd4, 32'd7, 32'd0, 0, "divu_zero");
        check("divu_zero_hi_const", mif.HI, 32'hFFFFFFFF);
        check("divu_zero_lo_const", mif.LO, 32'hFFFFFFFD);
        run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        check("div_ovf_hi_const", mif.HI, 32'h00000000);
        check("div_ovf_lo_const", mif.LO, 32'h80000000);

        // A start alongside a MEM-stage trap must leave no trace.
        mif.start = 1'b1; mif.op = 4'd3; mif.A = 32'd100; mif.B = 32'd7; mif.except = 1'b1;
        @(negedge clk);
        check("exc_div_busy", {31'd0, mif.busy}, 32'd0);
        mif.op = 4'd5; mif.A = 32'h55555555;
        @(negedge clk);
        check("exc_mthi_busy", {31'd0, mif.busy}, 32'd0);
        check("exc_hi", mif.HI, m_hi);
        check("exc_lo", mif.LO, m_lo);
        mif.start = 1'b0; mif.except = 1'b0; mif.op = 4'd0;
        run_md(4'd1, 32'h00012345, 32'hFFF54321, 1, "mult_exc_mid");

        mif.start = 1'b1; mif.op = 4'd5; mif.A = 32'h12345678;
        @(negedge clk);
        mif.start = 1'b0; mif.op = 4'd7; #1;
        check("mfhi", mif.mdu_rd, 32'h12345678);
        @(negedge clk);
        mif.start = 1'b1; mif.op = 4'd6; mif.A = 32'hCAFEBABE;
        @(negedge clk);
        mif.start = 1'b0; mif.op = 4'd8; #1;
        check("mflo", mif.mdu_rd, 32'hCAFEBABE);
        mif.op = 4'd7; #1;
        check("mfhi_after_mtlo", mif.mdu_rd, 32'h12345678);
        mif.op = 4'd0; #1;
        check("rd_none", mif.mdu_rd, 32'd0);
        mif.op = 4'd13; #1;
        check("rd_op13", mif.mdu_rd, 32'd0);
        m_hi = 32'h12345678; m_lo = 32'hCAFEBABE;
        @(negedge clk);
        mif.start = 1'b1; mif.op = 4'd13; mif.A = 32'hDEADBEEF;
        @(negedge clk);
        mif.start = 1'b0; mif.op = 4'd0;
        check("op13_busy", {31'd0, mif.busy}, 32'd0);
        check("op13_hi", mif.HI, m_hi);
        check("op13_lo", mif.LO, m_lo);

        run_md(4'd3, 32'd1000, 32'd7, 2, "ovl_div");
        run_md(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, "b2b_mult");

        for (int i = 0; i < 16; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 100));
                2:       rb = -32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            run_md(rop, ra, rb, 0, "rand");
            mif.op = 4'd7; #1;
            check("rand_mfhi", mif.mdu_rd, m_hi);
            mif.op = 4'd8; #1;
            check("rand_mflo", mif.mdu_rd, m_lo);
            mif.op = 4'd0;
        end

        // Reset lands while a mult has three cycles left.
        @(negedge clk);
        mif.start = 1'b1; mif.op = 4'd1; mif.A = 32'd3; mif.B = 32'd5;
        @(negedge clk);
        mif.start = 1'b0; mif.op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, mif.busy}, 32'd0);
        check("mid_rst_hi", mif.HI, 32'd0);
        check("mid_rst_lo", mif.LO, 32'd0);
        repeat (8) @(negedge clk);
        check("post_rst_hi", mif.HI, 32'd0);
        check("post_rst_lo", mif.LO, 32'd0);
        check("post_rst_busy", {31'd0, mif.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit inside the EX stage of the 5-stage MIPS pipeline, directly upstream of the MEM stage.
- Executes mult, multu, div and divu over several cycles, and owns the HI/LO registers. Also executes mthi, mtlo, mfhi and mflo.
- Exports `busy` to the hazard unit, which stalls any later MD-class instruction in D.
- Honours the MEM-stage exception flag: a younger MD instruction in EX must not commit when the instruction in MEM traps.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult and multu (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for div and divu (must be ≥1).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  valid MD-class instruction in EX this cycle.
- op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- except  input  1  exception/interrupt being taken on the instruction currently in MEM.
- busy  output  1  a multi-cycle operation is in progress.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- mdu_rd  output  32  mfhi/mflo result for the EX result mux.

Behaviour:
- Reset (reset=1 at an edge):
  - HI=0, LO=0, counter=0, busy=0, latched operands and latched op cleared.
  - Reset overrides everything, including an operation in progress; no HI/LO write occurs that edge.
- Accept rule: an op is accepted at an edge when start=1, except=0, busy=0, and op is in 1..6.
  - start with except=1: no effect at all. HI/LO, counter and busy are unchanged.
  - start with busy=1: ignored. The hazard unit guarantees this does not happen; the bench checks the block still tolerates it.
- mult/multu/div/divu:
  - On accept: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES.
  - busy = (counter != 0), a registered value. busy rises the cycle after accept and stays high exactly N cycles.
  - Counter decrements by 1 per edge while nonzero.
  - At the edge where the counter goes 1→0, HI/LO are written and busy falls. The new HI/LO are visible in the same cycle busy reads 0.
  - except asserted while busy=1 does NOT cancel: the running op belongs to an older instruction and completes normally.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO} = product.
  - multu: unsigned 32×32→64, {HI,LO} = product.
  - div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned. LO = A/B, HI = A%B.
  - Operands are the latched values; changes on A/B during busy have no effect.
  - Divisor = 0 (div or divu): operation still runs the full DIV_CYCLES with busy asserted, then HI and LO are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrapped result, no trap).
- mthi/mtlo:
  - On accept, HI (or LO) = A at that same edge. No busy cycles.
  - Visible to mfhi/mflo from the next cycle.
- mfhi/mflo:
  - Combinational: mdu_rd = HI when op=7, LO when op=8, otherwise 0. Independent of start.
  - No internal bypass: an mthi accepted at edge t is visible to mfhi from cycle t+1.
  - The hazard unit keeps mfhi/mflo in D while busy=1.
- Back-to-back: a new op may be accepted at the first edge where busy=0, i.e. the cycle after completion.
- No other outputs are registered or delayed.

Test Plan:
- Reset: reset=1 for 2 cycles with a mult pending (counter=3) → HI=LO=0, busy=0 the cycle after reset; HI/LO never take the product.
- mult latency: start, op=1, A=0xFFFFFFFF(−1), B=2 → busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div sign/latency: div A=−7, B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → busy 10 cycles; then HI/LO hold their prior values.
- Exception gating: start, op=3 with except=1 → busy stays 0, HI/LO unchanged. except=1 during cycle 3 of a running mult → completes on cycle 5 with the correct product.
- Move/read: mthi A=0x12345678 then mflo/mfhi next cycle → mdu_rd=0x12345678 for op=7. mtlo A=0xCAFEBABE → op=8 gives 0xCAFEBABE. op=0 → mdu_rd=0.
- Overlap: start mult while busy=1 from a div → ignored; div result written at cycle 10; a mult accepted the cycle after busy falls runs 5 cycles.
